// File: rtl/skid_pipestage_pkg.sv
// Shared types for skid_pipestage: stage state encoding and occupancy width.
// The state value doubles as the entry count driven on occupancy.
package skid_pipestage_pkg;

   localparam int unsigned OCC_W = 2;

   typedef enum logic [OCC_W-1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } stage_state_t;

   function automatic logic [OCC_W-1:0] occ_of(input stage_state_t s);
      logic [OCC_W-1:0] n;
      n = '0;
      case (s)
         EMPTY:   n = 2'd0;
         BUSY:    n = 2'd1;
         FULL:    n = 2'd2;
         default: n = 2'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/skid_pipestage_flopenrc.sv
// flopenrc: enabled data register with synchronous reset and synchronous clear.
module flopenrc #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/skid_pipestage.sv
// skid_pipestage: flushable valid/ready register stage. With SKID_PIPESTAGE_SKID_EN
// defined a skid register gives a registered in_ready; otherwise it is a single entry.
module skid_pipestage
   import skid_pipestage_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [OCC_W-1:0] occupancy
);

   stage_state_t     state;
   stage_state_t     state_next;
   logic             in_fire;
   logic             out_fire;
   logic             main_en;
   logic [WIDTH-1:0] main_d;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   flopenrc #(.WIDTH(WIDTH)) u_main (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .en    (main_en),
      .d     (main_d),
      .q     (out_data)
   );

`ifdef SKID_PIPESTAGE_SKID_EN

   logic             skid_en;
   logic [WIDTH-1:0] skid_q;

   flopenrc #(.WIDTH(WIDTH)) u_skid (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .en    (skid_en),
      .d     (in_data),
      .q     (skid_q)
   );

   always_comb begin
      state_next = state;
      case (state)
         EMPTY:   if (in_fire) state_next = BUSY;
         BUSY: begin
            if (in_fire && !out_fire) begin
               state_next = FULL;
            end else if (!in_fire && out_fire) begin
               state_next = EMPTY;
            end
         end
         FULL:    if (out_fire) state_next = BUSY;
         default: state_next = EMPTY;
      endcase
   end

   // Head refills from skid when FULL drains; otherwise it loads straight from upstream.
   always_comb begin
      main_en = 1'b0;
      main_d  = in_data;
      skid_en = 1'b0;
      case (state)
         EMPTY: main_en = in_fire;
         BUSY: begin
            main_en = in_fire & out_fire;
            skid_en = in_fire & ~out_fire;
         end
         FULL: begin
            main_en = out_fire;
            main_d  = skid_q;
         end
         default: main_en = 1'b0;
      endcase
   end

   always_comb begin
      out_valid = (state != EMPTY);
      in_ready  = (state != FULL) & ~reset;
      occupancy = occ_of(state);
   end

`else

   always_comb begin
      state_next = state;
      case (state)
         EMPTY:   if (in_fire) state_next = BUSY;
         BUSY:    if (out_fire && !in_fire) state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   // Without skid storage an upstream transfer in BUSY implies a downstream one.
   always_comb begin
      main_en = in_fire;
      main_d  = in_data;
   end

   always_comb begin
      out_valid = (state != EMPTY);
      in_ready  = (~out_valid | out_ready) & ~reset;
      occupancy = occ_of(state);
   end

`endif

endmodule

// File: tb/tb_skid_pipestage.sv
// Bench for skid_pipestage: directed steps plus random traffic against a bounded-queue model.
// Follows SKID_PIPESTAGE_SKID_EN to pick the model's capacity and ready rule.
module tb_skid_pipestage;

   logic       clk;
   logic       reset;
   logic       clear;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [1:0] occupancy;

   int unsigned checks;
   int unsigned errors;
   logic [7:0]  model_q[$];
   logic [7:0]  stale;
   logic        watch33;
   logic        saw33;

   skid_pipestage #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One clock: drive inputs, check outputs at negedge against the model, then advance the model.
   task automatic cycle(input logic rst, input logic clr, input logic iv,
                        input logic [7:0] id, input logic ordy);
      logic       e_ir;
      logic       e_ov;
      logic [7:0] e_od;
      logic [7:0] w;
      int unsigned n;
      reset     = rst;
      clear     = clr;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      n = model_q.size();
`ifdef SKID_PIPESTAGE_SKID_EN
      e_ir = !rst && (n < 2);
`else
      e_ir = !rst && ((n == 0) || ordy);
`endif
      e_ov = (n != 0);
      e_od = (n != 0) ? model_q[0] : stale;
      @(negedge clk);
      chk("in_ready", {31'd0, in_ready}, {31'd0, e_ir});
      chk("out_valid", {31'd0, out_valid}, {31'd0, e_ov});
      chk("out_data", {24'd0, out_data}, {24'd0, e_od});
      chk("occupancy", {30'd0, occupancy}, n);
      if (watch33 && out_valid === 1'b1 && out_data === 8'h33) saw33 = 1'b1;
      @(posedge clk);
      #1;
      if (rst || clr) begin
         model_q.delete();
         stale = 8'h00;
      end else begin
         if (e_ov && ordy) begin
            w = model_q.pop_front();
            if (model_q.size() == 0) stale = w;
         end
         if (iv && e_ir) model_q.push_back(id);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      stale     = 8'h00;
      watch33   = 1'b0;
      saw33     = 1'b0;
      reset     = 1'b1;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state, then first cycle after release.
      cycle(1'b1, 1'b0, 1'b1, 8'hEE, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

      // Streaming 0x01..0x10 with out_ready held high.
      for (int i = 1; i <= 16; i++) cycle(1'b0, 1'b0, 1'b1, 8'(i), 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

      // Back-pressure: 0xA5 held, 0x3C offered while out_ready low, then release.
      cycle(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 8'h3C, 1'b0);
`ifdef SKID_PIPESTAGE_SKID_EN
      chk("bp_occupancy", {30'd0, occupancy}, 32'd2);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_head", {24'd0, out_data}, 32'h0A5);
`endif
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

      // Flush while full (or busy) with 0x33 offered on the clear cycle.
      cycle(1'b0, 1'b0, 1'b1, 8'h11, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 8'h22, 1'b0);
      watch33 = 1'b1;
      cycle(1'b0, 1'b1, 1'b1, 8'h33, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("flush_no_33", {31'd0, saw33}, 32'd0);
      watch33 = 1'b0;

      // Drain from full: occupancy 2, 1, 0 in skid mode.
      cycle(1'b0, 1'b0, 1'b1, 8'h44, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

      // Reset mid-stream while busy.
      cycle(1'b0, 1'b0, 1'b1, 8'h66, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 8'h77, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("post_reset_data", {24'd0, out_data}, 32'd0);

`ifndef SKID_PIPESTAGE_SKID_EN
      // Combinational ready: tracks out_ready within the same cycle.
      cycle(1'b0, 1'b0, 1'b1, 8'h81, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 8'h82, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 8'h82, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
`endif

      // Random traffic with occasional clear and reset.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(99) < 1), ($urandom_range(99) < 3),
               ($urandom_range(99) < 70), 8'($urandom), ($urandom_range(99) < 60));
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
